// File: rtl/dram_port_arbiter_if.sv
// Bundle of client request/ack channels, the DRAM port and status flags
// for the three-client DRAM port arbiter. The arbiter connects through
// the slave modport; whatever drives the clients and the DRAM model uses
// the master modport.
interface dram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              c0_req, c1_req, c2_req;
  logic              c0_we, c1_we, c2_we;
  logic [ADDR_W-1:0] c0_addr, c1_addr, c2_addr;
  logic [DATA_W-1:0] c0_wdata, c1_wdata, c2_wdata;
  logic              c0_ack, c1_ack, c2_ack;
  logic [DATA_W-1:0] rdata;
  logic              prio0;
  logic              dram_req, dram_we;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_data;
  logic              dram_ack;
  logic [DATA_W-1:0] dram_rdata;
  logic              busy, ack_err;

  modport slave (
    input  c0_req, c1_req, c2_req, c0_we, c1_we, c2_we,
           c0_addr, c1_addr, c2_addr, c0_wdata, c1_wdata, c2_wdata,
           prio0, dram_ack, dram_rdata,
    output c0_ack, c1_ack, c2_ack, rdata, dram_req, dram_we,
           dram_addr, dram_data, busy, ack_err
  );

  modport master (
    output c0_req, c1_req, c2_req, c0_we, c1_we, c2_we,
           c0_addr, c1_addr, c2_addr, c0_wdata, c1_wdata, c2_wdata,
           prio0, dram_ack, dram_rdata,
    input  c0_ack, c1_ack, c2_ack, rdata, dram_req, dram_we,
           dram_addr, dram_data, busy, ack_err
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Three-client DRAM port arbiter. One transaction in flight at a time:
// IDLE picks a winner (client 0 under prio0, else round-robin after the
// last served client), ISSUE holds the registered DRAM request until
// dram_ack, HOLD is a single cycle carrying the client ack pulse so the
// client can drop its request before the next arbitration.
module dram_port_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  dram_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [1:0]        last, grant;
  logic [2:0]        req_vec;
  logic [2:0]        pick;
  logic              win_valid;
  logic [1:0]        winner;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              dram_req_r, dram_we_r, busy_r, ack_err_r;
  logic [ADDR_W-1:0] dram_addr_r;
  logic [DATA_W-1:0] dram_data_r, rdata_r;
  logic [2:0]        ack_r;

  // Returns {valid, index} of the first requesting client in order a, b, c.
  function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                         input logic [1:0] a,
                                         input logic [1:0] b,
                                         input logic [1:0] c);
    if (req[a])      return {1'b1, a};
    else if (req[b]) return {1'b1, b};
    else if (req[c]) return {1'b1, c};
    else             return 3'b000;
  endfunction

  assign req_vec = {bus.c2_req, bus.c1_req, bus.c0_req};

  // Winner selection: prio0 overrides, otherwise search from last+1.
  always_comb begin
    pick = 3'b000;
    if (bus.prio0 && req_vec[0]) begin
      pick = 3'b100;
    end else begin
      case (last)
        2'd0:    pick = rr_pick(req_vec, 2'd1, 2'd2, 2'd0);
        2'd1:    pick = rr_pick(req_vec, 2'd2, 2'd0, 2'd1);
        default: pick = rr_pick(req_vec, 2'd0, 2'd1, 2'd2);
      endcase
    end
  end

  assign win_valid = pick[2];
  assign winner    = pick[1:0];

  // Mux the winning client's request fields.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = {ADDR_W{1'b0}};
    win_wdata = {DATA_W{1'b0}};
    case (winner)
      2'd0: begin win_we = bus.c0_we; win_addr = bus.c0_addr; win_wdata = bus.c0_wdata; end
      2'd1: begin win_we = bus.c1_we; win_addr = bus.c1_addr; win_wdata = bus.c1_wdata; end
      2'd2: begin win_we = bus.c2_we; win_addr = bus.c2_addr; win_wdata = bus.c2_wdata; end
      default: begin win_we = 1'b0; win_addr = {ADDR_W{1'b0}}; win_wdata = {DATA_W{1'b0}}; end
    endcase
  end

  // Next-state logic of the IDLE/ISSUE/HOLD controller.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (win_valid) state_next = ISSUE;
        else           state_next = IDLE;
      end
      ISSUE: begin
        if (bus.dram_ack) state_next = HOLD;
        else              state_next = ISSUE;
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Registered DRAM request, client acks, read data and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      last        <= 2'd2;
      grant       <= 2'd0;
      dram_req_r  <= 1'b0;
      dram_we_r   <= 1'b0;
      dram_addr_r <= {ADDR_W{1'b0}};
      dram_data_r <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      ack_r       <= 3'b000;
      busy_r      <= 1'b0;
      ack_err_r   <= 1'b0;
    end else begin
      ack_r  <= 3'b000;
      busy_r <= (state_next != IDLE);
      // A DRAM completion with nothing outstanding is a protocol error.
      if (bus.dram_ack && (state != ISSUE)) ack_err_r <= 1'b1;
      else                                  ack_err_r <= ack_err_r;
      case (state)
        IDLE: begin
          if (win_valid) begin
            dram_req_r  <= 1'b1;
            dram_we_r   <= win_we;
            dram_addr_r <= win_addr;
            dram_data_r <= win_we ? win_wdata : {DATA_W{1'b0}};
            grant       <= winner;
          end else begin
            dram_req_r  <= 1'b0;
          end
        end
        ISSUE: begin
          if (bus.dram_ack) begin
            dram_req_r  <= 1'b0;
            dram_we_r   <= 1'b0;
            dram_addr_r <= {ADDR_W{1'b0}};
            dram_data_r <= {DATA_W{1'b0}};
            ack_r       <= 3'b001 << grant;
            last        <= grant;
            if (!dram_we_r) rdata_r <= bus.dram_rdata;
            else            rdata_r <= rdata_r;
          end else begin
            dram_req_r  <= dram_req_r;
          end
        end
        HOLD:    dram_req_r <= 1'b0;
        default: dram_req_r <= 1'b0;
      endcase
    end
  end

  assign bus.dram_req  = dram_req_r;
  assign bus.dram_we   = dram_we_r;
  assign bus.dram_addr = dram_addr_r;
  assign bus.dram_data = dram_data_r;
  assign bus.c0_ack    = ack_r[0];
  assign bus.c1_ack    = ack_r[1];
  assign bus.c2_ack    = ack_r[2];
  assign bus.rdata     = rdata_r;
  assign bus.busy      = busy_r;
  assign bus.ack_err   = ack_err_r;

endmodule
